tff_bank: RTL and testbench
===========================

Name: tff_bank

Overview:
- Parametrised bank of WIDTH T flip-flops with no preset input.
- Four run-time modes: hold, per-bit toggle, count up, count down. Counting is built from T-flip-flop toggle terms.
- Adds a synchronous load, a registered terminal-count pulse and a change flag.
- Carries its own SVA checks for the hold and toggle rules. It is the general successor to the single T flip-flop check and is used as a counter/toggle primitive in later blocks.

Parameters:
- WIDTH, 8, number of T flip-flops in the bank (1..32).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- ASSERT_EN, 1, 1 compiles the embedded SVA properties; 0 removes them.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  step enable; 0 means hold.
- mode  input  2  00 hold, 01 toggle, 10 count up, 11 count down.
- t  input  WIDTH  per-bit toggle request; used in mode 01 only.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value written on load.
- q  output  WIDTH  flip-flop bank state.
- tc  output  1  registered one-cycle wrap pulse.
- changed  output  1  registered; 1 when q changed at the last edge.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n. All state updates only on posedge clk.
- Reset: rst_n=0 at an edge sets q=RESET_VAL, tc=0, changed=0. It overrides load and en. Asserting reset mid-count aborts the count with no tc.
- Priority per edge: reset > load > (en and mode) > hold.
- load=1: q<=load_val and tc<=0, regardless of en and mode. changed<=(load_val!=q).
- en=0 or mode=00: q holds, tc<=0, changed<=0.
- mode=01 (toggle): q<=q^t. Bits with t[i]=0 hold; bits with t[i]=1 invert. tc<=0. changed<=|t.
- mode=10 (count up): per-bit toggle term T[0]=1, T[i]=&q[i-1:0]; q<=q^T, which equals q+1 mod 2^WIDTH. tc<=1 only when the old q was all ones (wrap to 0). changed<=1.
- mode=11 (count down): T[0]=1, T[i]=&(~q[i-1:0]); q<=q-1 mod 2^WIDTH. tc<=1 only when the old q was 0 (wrap to all ones). changed<=1.
- Latency: q reflects the action one edge after the inputs are sampled. tc and changed are registered alongside q and describe that same transition.
- tc is a single-cycle pulse. Consecutive wraps are possible only when WIDTH=1, and then tc stays high on each wrapping edge.
- Mode changes take effect at the next edge. There is no pipeline and no state beyond q, tc and changed.
- WIDTH=1: the up and down modes both reduce to a plain toggle. tc pulses on the 1->0 edge for up and the 0->1 edge for down.
- Embedded SVA (ASSERT_EN=1), all gated with disable iff (!rst_n):
  - Any step that is not a load and not an enabled active mode implies q==$past(q) at the next edge.
  - Enabled mode 01 without load implies q==$past(q)^$past(t).
  - Enabled mode 10 without load implies q==$past(q)+1 truncated to WIDTH.
  - Enabled mode 11 without load implies q==$past(q)-1 truncated to WIDTH.
  - tc implies the previous q was the wrap value for the previous mode.
  - Load implies q==$past(load_val).

Test Plan:
- WIDTH=4, RESET_VAL=4'h5: hold rst_n=0 for 2 edges, then release -> q=4'h5, tc=0, changed=0; with en=0, q stays 5 for 3 edges.
- mode=01, en=1, q=4'h0; t=4'b1010, then 4'b0000, then 4'b1111 -> q=4'hA (changed=1), 4'hA (changed=0), 4'h5 (changed=1); tc=0 throughout.
- mode=10, load 4'hE then count 3 edges -> q=E,F,0,1; tc=1 only in the cycle q=0.
- mode=11 from q=4'h1, 3 edges -> q=0,F,E; tc=1 only in the cycle q=F.
- Priority: load=1 with load_val=4'h3, en=1, mode=10, q=4'hF at the same edge -> q=3, tc=0. Next edge rst_n=0 with load=1 -> q=RESET_VAL.
- Assertion self-check: force a wrong q in a bind or bench copy during mode 01 -> the toggle assertion fires. Run with ASSERT_EN=0 -> it compiles and no assertions are reported.

Source files
------------

// File: rtl/tff_bank.sv
// rtl/tff_bank.sv - bank of WIDTH T flip-flops with toggle, up/down count, load,
// registered wrap pulse (tc) and change flag.
module tff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ASSERT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             changed
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;

  function automatic logic [WIDTH-1:0] low_mask(input int n);
    low_mask = (WIDTH'(1) << n) - WIDTH'(1);
  endfunction

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
  always_comb begin
    up_t = '0;
    dn_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = ((q & low_mask(i)) == low_mask(i));
      dn_t[i] = ((q & low_mask(i)) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= RESET_VAL;
      tc      <= 1'b0;
      changed <= 1'b0;
    end else if (load) begin
      q       <= load_val;
      tc      <= 1'b0;
      changed <= (load_val != q);
    end else if (!en) begin
      tc      <= 1'b0;
      changed <= 1'b0;
    end else begin
      case (mode)
        MODE_HOLD: begin
          tc      <= 1'b0;
          changed <= 1'b0;
        end
        MODE_TOGGLE: begin
          q       <= q ^ t;
          tc      <= 1'b0;
          changed <= |t;
        end
        MODE_UP: begin
          q       <= q ^ up_t;
          tc      <= &q;
          changed <= 1'b1;
        end
        MODE_DOWN: begin
          q       <= q ^ dn_t;
          tc      <= ~|q;
          changed <= 1'b1;
        end
      endcase
    end
  end

  if (ASSERT_EN) begin : g_sva
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (!load && !(en && mode != MODE_HOLD)) |=> (q == $past(q)));

    a_toggle: assert property (@(posedge clk) disable iff (!rst_n)
      (!load && en && mode == MODE_TOGGLE) |=> (q == ($past(q) ^ $past(t))));

    a_up: assert property (@(posedge clk) disable iff (!rst_n)
      (!load && en && mode == MODE_UP) |=> (q == $past(q) + WIDTH'(1)));

    a_down: assert property (@(posedge clk) disable iff (!rst_n)
      (!load && en && mode == MODE_DOWN) |=> (q == $past(q) - WIDTH'(1)));

    a_tc: assert property (@(posedge clk) disable iff (!rst_n)
      tc |-> ($past(en) && (($past(mode) == MODE_UP && $past(q) == '1) ||
                            ($past(mode) == MODE_DOWN && $past(q) == '0))));

    a_load: assert property (@(posedge clk) disable iff (!rst_n)
      load |=> (q == $past(load_val)));
  end

endmodule

// File: tb/tb_tff_bank.sv
// tb/tb_tff_bank.sv - scoreboard bench for tff_bank: WIDTH=4 instance with
// assertions and a WIDTH=1 instance with assertions compiled out.
module tb_tff_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] t = 4'h0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] q;
  logic       tc;
  logic       changed;
  logic [0:0] q1;
  logic       tc1;
  logic       changed1;

  always #5 clk = ~clk;

  tff_bank #(.WIDTH(4), .RESET_VAL(4'h5), .ASSERT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .changed(changed)
  );

  tff_bank #(.WIDTH(1), .RESET_VAL(1'b0), .ASSERT_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t[0:0]), .load(load),
    .load_val(load_val[0:0]), .q(q1), .tc(tc1), .changed(changed1)
  );

  typedef struct {
    int         cyc;
    string      name;
    bit         chk4;
    logic [3:0] q;
    logic       tc;
    logic       ch;
    bit         chk1;
    logic       q1;
    logic       tc1;
    logic       ch1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: compares every expectation whose target edge has just occurred.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        check({mon_e.name, "_stale"}, 4'(cyc), 4'(mon_e.cyc));
      end else begin
        if (mon_e.chk4) begin
          check({mon_e.name, "_q"}, q, mon_e.q);
          check({mon_e.name, "_tc"}, {3'b0, tc}, {3'b0, mon_e.tc});
          check({mon_e.name, "_changed"}, {3'b0, changed}, {3'b0, mon_e.ch});
        end
        if (mon_e.chk1) begin
          check({mon_e.name, "_w1_q"}, {3'b0, q1}, {3'b0, mon_e.q1});
          check({mon_e.name, "_w1_tc"}, {3'b0, tc1}, {3'b0, mon_e.tc1});
          check({mon_e.name, "_w1_changed"}, {3'b0, changed1}, {3'b0, mon_e.ch1});
        end
      end
    end
  end

  task automatic step(input logic rn, input logic ld, input logic [3:0] lv,
                      input logic e, input logic [1:0] m, input logic [3:0] tt,
                      input bit c4, input logic [3:0] eq, input logic etc, input logic ech,
                      input bit c1, input logic eq1, input logic etc1, input logic ech1,
                      input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rn; load = ld; load_val = lv; en = e; mode = m; t = tt;
    x.cyc = cyc + 1; x.name = nm;
    x.chk4 = c4; x.q = eq; x.tc = etc; x.ch = ech;
    x.chk1 = c1; x.q1 = eq1; x.tc1 = etc1; x.ch1 = ech1;
    sb.push_back(x);
  endtask

  initial begin
    //    rn  ld  lv    en  mode   t       c4 q    tc ch   c1 q1 tc1 ch1
    step(0, 0, 4'h0, 0, 2'b00, 4'h0,  1, 4'h5, 0, 0,  0, 0, 0, 0, "reset1");
    step(0, 0, 4'h0, 0, 2'b00, 4'h0,  1, 4'h5, 0, 0,  0, 0, 0, 0, "reset2");
    for (int i = 0; i < 3; i++)
      step(1, 0, 4'h0, 0, 2'b10, 4'hF, 1, 4'h5, 0, 0, 0, 0, 0, 0, "hold_en0");
    step(1, 0, 4'h0, 1, 2'b00, 4'hF,  1, 4'h5, 0, 0,  0, 0, 0, 0, "hold_mode0");
    step(1, 1, 4'h0, 0, 2'b00, 4'h0,  1, 4'h0, 0, 1,  0, 0, 0, 0, "load0");
    step(1, 0, 4'h0, 1, 2'b01, 4'hA,  1, 4'hA, 0, 1,  0, 0, 0, 0, "tog_1010");
    step(1, 0, 4'h0, 1, 2'b01, 4'h0,  1, 4'hA, 0, 0,  0, 0, 0, 0, "tog_0000");
    step(1, 0, 4'h0, 1, 2'b01, 4'hF,  1, 4'h5, 0, 1,  0, 0, 0, 0, "tog_1111");
    step(1, 1, 4'hE, 1, 2'b10, 4'h0,  1, 4'hE, 0, 1,  0, 0, 0, 0, "load_e");
    step(1, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'hF, 0, 1,  0, 0, 0, 0, "up_f");
    step(1, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'h0, 1, 1,  0, 0, 0, 0, "up_wrap");
    step(1, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'h1, 0, 1,  0, 0, 0, 0, "up_1");
    step(1, 0, 4'h0, 1, 2'b11, 4'h0,  1, 4'h0, 0, 1,  0, 0, 0, 0, "dn_0");
    step(1, 0, 4'h0, 1, 2'b11, 4'h0,  1, 4'hF, 1, 1,  0, 0, 0, 0, "dn_wrap");
    step(1, 0, 4'h0, 1, 2'b11, 4'h0,  1, 4'hE, 0, 1,  0, 0, 0, 0, "dn_e");
    step(1, 1, 4'hE, 1, 2'b11, 4'h0,  1, 4'hE, 0, 0,  0, 0, 0, 0, "load_same");
    step(1, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'hF, 0, 1,  0, 0, 0, 0, "up_to_f");
    step(1, 1, 4'h3, 1, 2'b10, 4'h0,  1, 4'h3, 0, 1,  0, 0, 0, 0, "load_over_wrap");
    step(0, 1, 4'h9, 1, 2'b10, 4'h0,  1, 4'h5, 0, 0,  0, 0, 0, 0, "reset_over_load");
    step(1, 1, 4'hF, 1, 2'b10, 4'h0,  1, 4'hF, 0, 1,  0, 0, 0, 0, "load_f");
    step(0, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'h5, 0, 0,  1, 0, 0, 0, "reset_abort");
    step(1, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'h6, 0, 1,  1, 1, 0, 1, "w1_up_a");
    step(1, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'h7, 0, 1,  1, 0, 1, 1, "w1_up_wrap");
    step(1, 0, 4'h0, 1, 2'b10, 4'h0,  1, 4'h8, 0, 1,  1, 1, 0, 1, "w1_up_b");
    step(1, 0, 4'h0, 1, 2'b11, 4'h0,  1, 4'h7, 0, 1,  1, 0, 0, 1, "w1_dn_a");
    step(1, 0, 4'h0, 1, 2'b11, 4'h0,  1, 4'h6, 0, 1,  1, 1, 1, 1, "w1_dn_wrap");
    step(1, 0, 4'h0, 1, 2'b11, 4'h0,  1, 4'h5, 0, 1,  1, 0, 0, 1, "w1_dn_b");
    @(posedge clk);
    #1;
    en = 1'b0; mode = 2'b00;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
